// File: rtl/seq_detect_scheduler_if.sv
// Request/grant bundle between two word requesters and the 010/101 scan scheduler.
// master = requester side, slave = scheduler side.
interface seq_detect_scheduler_if;
  logic       req0;
  logic       req1;
  logic [7:0] data0;
  logic [7:0] data1;
  logic [1:0] gnt;
  logic       busy;
  logic       y;
  logic       done;
  logic       owner;
  logic [3:0] match_cnt;

  modport master (
    output req0, req1, data0, data1,
    input  gnt, busy, y, done, owner, match_cnt
  );

  modport slave (
    input  req0, req1, data0, data1,
    output gnt, busy, y, done, owner, match_cnt
  );
endinterface

// File: rtl/seq_detect_scheduler.sv
// Round-robin two-requester scheduler feeding 8-bit words MSB first into a 010/101 detector.
// Grant at E0, bits at E1..E8, done after E8; reqs ignored while busy. Macro SEQ_OVERLAP_EN keeps history after a match.
module seq_detect_scheduler (
  input  logic                   clk,
  input  logic                   reset,
  seq_detect_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] hist_q, hist_d;
  logic [1:0] hist_len_q, hist_len_d;
  logic       owner_q, owner_d;
  logic [3:0] match_cnt_q, match_cnt_d;
  logic       y_q, y_d;
  logic [1:0] gnt_q, gnt_d;

  logic       winner;
  logic       bit_in;
  logic       is_match;

  // Tie goes to whoever was not served last; owner resets to 1 so requester 0 wins first.
  always_comb begin
    winner = 1'b0;
    if (bus.req0 && bus.req1) begin
      winner = ~owner_q;
    end else if (bus.req1) begin
      winner = 1'b1;
    end
  end

  assign bit_in   = data_q[7];
  assign is_match = (hist_len_q == 2'd2) && (hist_q[1] != hist_q[0]) && (hist_q[0] != bit_in);

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    bit_cnt_d   = bit_cnt_q;
    hist_d      = hist_q;
    hist_len_d  = hist_len_q;
    owner_d     = owner_q;
    match_cnt_d = match_cnt_q;
    y_d         = 1'b0;
    gnt_d       = 2'b00;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          data_d      = winner ? bus.data1 : bus.data0;
          owner_d     = winner;
          match_cnt_d = 4'd0;
          hist_d      = 2'b00;
          hist_len_d  = 2'd0;
          bit_cnt_d   = 3'd0;
          gnt_d       = winner ? 2'b10 : 2'b01;
          state_d     = SHIFT;
        end
      end

      SHIFT: begin
        data_d     = {data_q[6:0], 1'b0};
        hist_d     = {hist_q[0], bit_in};
        hist_len_d = (hist_len_q == 2'd2) ? 2'd2 : hist_len_q + 2'd1;
        if (is_match) begin
          y_d         = 1'b1;
          match_cnt_d = match_cnt_q + 4'd1;
`ifdef SEQ_OVERLAP_EN
          hist_len_d  = 2'd2;
`else
          // Non-overlapping: the next match needs three fresh bits.
          hist_d      = 2'b00;
          hist_len_d  = 2'd0;
`endif
        end
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          state_d = DONE;
        end
      end

      DONE: begin
        hist_len_d = 2'd0;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      data_q      <= 8'h00;
      bit_cnt_q   <= 3'd0;
      hist_q      <= 2'b00;
      hist_len_q  <= 2'd0;
      owner_q     <= 1'b1;
      match_cnt_q <= 4'd0;
      y_q         <= 1'b0;
      gnt_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      bit_cnt_q   <= bit_cnt_d;
      hist_q      <= hist_d;
      hist_len_q  <= hist_len_d;
      owner_q     <= owner_d;
      match_cnt_q <= match_cnt_d;
      y_q         <= y_d;
      gnt_q       <= gnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.y         = y_q;
  assign bus.done      = (state_q == DONE);
  assign bus.owner     = owner_q;
  assign bus.match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed bench for seq_detect_scheduler: hand-computed grants, y bit-masks and match counts.
// y mask bit n is set when the match lands on data bit n (bit7 is fed first).
module tb_seq_detect_scheduler;

  logic clk;
  logic reset;
  int   vec_cnt;
  int   err_cnt;

  seq_detect_scheduler_if bus_if ();

  seq_detect_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SEQ_OVERLAP_EN
  localparam logic [7:0] MASK_55 = 8'h3F;
  localparam logic [3:0] CNT_55  = 4'd6;
  localparam logic [7:0] MASK_A4 = 8'h32;
  localparam logic [3:0] CNT_A4  = 4'd3;
`else
  localparam logic [7:0] MASK_55 = 8'h24;
  localparam logic [3:0] CNT_55  = 4'd2;
  localparam logic [7:0] MASK_A4 = 8'h22;
  localparam logic [3:0] CNT_A4  = 4'd2;
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller drives req/data beforehand; covers grant edge E0 through return to IDLE at E9.
  task automatic run_word(input string tag, input logic exp_win, input logic [7:0] exp_mask,
                          input logic [3:0] exp_cnt, input bit drop, input bit toggle1);
    logic [7:0] ymask;
    logic [1:0] gacc;
    logic       dacc;
    tick();
    chk({tag, "_gnt"}, {30'd0, bus_if.gnt}, exp_win ? 32'd2 : 32'd1);
    chk({tag, "_busy0"}, {31'd0, bus_if.busy}, 32'd1);
    chk({tag, "_owner"}, {31'd0, bus_if.owner}, {31'd0, exp_win});
    chk({tag, "_cnt_clr"}, {28'd0, bus_if.match_cnt}, 32'd0);
    if (drop) begin
      bus_if.req0 = 1'b0;
      bus_if.req1 = 1'b0;
    end
    ymask = 8'h00;
    gacc  = 2'b00;
    dacc  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (toggle1) bus_if.req1 = ~bus_if.req1;
      tick();
      ymask[7-k] = bus_if.y;
      gacc       = gacc | bus_if.gnt;
      if (k < 7) dacc = dacc | bus_if.done;
    end
    if (toggle1) bus_if.req1 = 1'b0;
    chk({tag, "_ymask"}, {24'd0, ymask}, {24'd0, exp_mask});
    chk({tag, "_gnt_quiet"}, {30'd0, gacc}, 32'd0);
    chk({tag, "_early_done"}, {31'd0, dacc}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus_if.done}, 32'd1);
    chk({tag, "_busy_done"}, {31'd0, bus_if.busy}, 32'd1);
    chk({tag, "_cnt"}, {28'd0, bus_if.match_cnt}, {28'd0, exp_cnt});
    tick();
    chk({tag, "_done_off"}, {31'd0, bus_if.done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, bus_if.busy}, 32'd0);
    chk({tag, "_gnt_idle"}, {30'd0, bus_if.gnt}, 32'd0);
    chk({tag, "_cnt_hold"}, {28'd0, bus_if.match_cnt}, {28'd0, exp_cnt});
    chk({tag, "_owner_hold"}, {31'd0, bus_if.owner}, {31'd0, exp_win});
  endtask

  initial begin
    logic dacc;
    vec_cnt      = 0;
    err_cnt      = 0;
    reset        = 1'b0;
    bus_if.req0  = 1'b1;
    bus_if.req1  = 1'b0;
    bus_if.data0 = 8'h55;
    bus_if.data1 = 8'h00;

    // Reset wins over a pending request.
    tick();
    tick();
    chk("rst_gnt", {30'd0, bus_if.gnt}, 32'd0);
    chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("rst_y", {31'd0, bus_if.y}, 32'd0);
    chk("rst_done", {31'd0, bus_if.done}, 32'd0);
    chk("rst_owner", {31'd0, bus_if.owner}, 32'd1);
    chk("rst_cnt", {28'd0, bus_if.match_cnt}, 32'd0);
    bus_if.req0 = 1'b0;
    reset       = 1'b1;
    tick();
    chk("idle_busy", {31'd0, bus_if.busy}, 32'd0);

    bus_if.req0  = 1'b1;
    bus_if.data0 = 8'h55;
    run_word("w55", 1'b0, MASK_55, CNT_55, 1'b1, 1'b0);

    bus_if.req0  = 1'b1;
    bus_if.data0 = 8'hA4;
    run_word("wA4", 1'b0, MASK_A4, CNT_A4, 1'b1, 1'b0);

    bus_if.req1  = 1'b1;
    bus_if.data1 = 8'h00;
    run_word("w00", 1'b1, 8'h00, 4'd0, 1'b1, 1'b0);

    bus_if.req1  = 1'b1;
    bus_if.data1 = 8'hFF;
    run_word("wFF", 1'b1, 8'h00, 4'd0, 1'b1, 1'b0);

    // req1 toggling mid-word must neither grant nor disturb the req0 word.
    bus_if.req0  = 1'b1;
    bus_if.data0 = 8'h55;
    bus_if.data1 = 8'hFF;
    run_word("wtog", 1'b0, MASK_55, CNT_55, 1'b1, 1'b1);

    // Abort at the 4th shift edge.
    bus_if.req0  = 1'b1;
    bus_if.data0 = 8'h55;
    tick();
    chk("ab_gnt", {30'd0, bus_if.gnt}, 32'd1);
    bus_if.req0 = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("ab_gnt0", {30'd0, bus_if.gnt}, 32'd0);
    chk("ab_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("ab_y", {31'd0, bus_if.y}, 32'd0);
    chk("ab_done", {31'd0, bus_if.done}, 32'd0);
    chk("ab_cnt", {28'd0, bus_if.match_cnt}, 32'd0);
    chk("ab_owner", {31'd0, bus_if.owner}, 32'd1);
    reset = 1'b1;
    dacc  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      dacc = dacc | bus_if.done | bus_if.busy;
    end
    chk("ab_no_done", {31'd0, dacc}, 32'd0);

    // Both held high: grants alternate 0,1,0.
    bus_if.req0  = 1'b1;
    bus_if.req1  = 1'b1;
    bus_if.data0 = 8'h55;
    bus_if.data1 = 8'hA4;
    run_word("rr0", 1'b0, MASK_55, CNT_55, 1'b0, 1'b0);
    run_word("rr1", 1'b1, MASK_A4, CNT_A4, 1'b0, 1'b0);
    run_word("rr2", 1'b0, MASK_55, CNT_55, 1'b0, 1'b0);
    bus_if.req0 = 1'b0;
    bus_if.req1 = 1'b0;
    tick();
    chk("end_gnt", {30'd0, bus_if.gnt}, 32'd0);
    chk("end_busy", {31'd0, bus_if.busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/seq_detect_scheduler.md
SEQ_DETECT_SCHEDULER -- requirements
Module: seq_detect_scheduler

Interface
REQ-001 The block SHALL expose: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 The block SHALL expose: reset  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-003 The block SHALL expose: req0, req1  input  1 each  requester 0/1 word-scan request, held high until granted.
REQ-004 The block SHALL expose: data0, data1  input  8 each  requester word, valid while the matching req is high.
REQ-005 The block SHALL expose: gnt  output  2  one-hot grant pulse; bit n = requester n.
REQ-006 The block SHALL expose: busy  output  1  high while a word is being scanned.
REQ-007 The block SHALL expose: y  output  1  registered match pulse from the internal 010/101 detector.
REQ-008 The block SHALL expose: done  output  1  one-cycle pulse marking scan completion.
REQ-009 The block SHALL expose: owner  output  1  index of the requester currently or last served.
REQ-010 The block SHALL expose: match_cnt  output  4  number of 010/101 matches in the last scanned word.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 IDLE transitions: at an edge with (req0|req1) high, latch the winner's data, set owner, clear match_cnt and detector history, pulse gnt[winner] for the next cycle, go to SHIFT; otherwise stay in IDLE.
REQ-013 Arbitration: a single requester wins outright; if both are high, the requester not equal to owner wins (round-robin); after reset, requester 0 wins a tie.
REQ-014 SHIFT: on each of 8 consecutive edges, feed one latched bit MSB first (bit7 on the first edge) into the detector; after the 8th edge, go to DONE.
REQ-015 Detector: a match occurs on a fed bit when it and the two preceding fed bits of the same word form 010 or 101; history never crosses word boundaries.
REQ-016 On a match edge, y SHALL be high for the following cycle and match_cnt SHALL increment (maximum 6, no wrap possible).
REQ-017 DONE: done high for exactly one cycle, then return to IDLE; match_cnt and owner hold until the next grant.
REQ-018 busy SHALL be high in SHIFT and DONE, low in IDLE; gnt SHALL be zero except during the cycle immediately after a grant edge.
REQ-019 req inputs SHALL be ignored outside IDLE; a request still high in IDLE after DONE is re-arbitrated normally.
REQ-020 Latency: grant edge E0, bits at E1..E8, done high in the cycle after E8, next grant no earlier than E10.

Reset
REQ-021 With reset low at a clock edge: state=IDLE; gnt=0, busy=0, y=0, done=0, owner=1 (so requester 0 wins the first tie), match_cnt=0; detector history cleared.
REQ-022 A reset during SHIFT or DONE SHALL abort the word without a done pulse; that requester must re-request.
REQ-023 Reset SHALL take priority over every other event at the same edge.

Configuration
REQ-024 With macro SEQ_OVERLAP_EN defined, detector history SHALL be retained after a match (overlapping matches count).
REQ-025 Without SEQ_OVERLAP_EN, detector history SHALL be cleared after each match, so the next match needs three fresh bits.

Verification
REQ-026 Request word 0x55 on req0 alone -> gnt=01 for one cycle, done after 8 shift edges; match_cnt=6 with SEQ_OVERLAP_EN, 2 without; y pulses accordingly.
REQ-027 Request words 0x00 and 0xFF on req1 -> match_cnt=0, y never high, owner=1.
REQ-028 Assert req0 and req1 together right after reset, keeping both high -> grants alternate 0,1,0 with done between each.
REQ-029 Request word 0xA4 (10100100) -> matches on bits 5, 4, and 1 (overlap: 101, 010, 010): match_cnt=3 with SEQ_OVERLAP_EN, 2 without.
REQ-030 Pull reset low on the 4th shift edge -> all outputs zero next cycle, no done pulse, next tie granted to requester 0.
REQ-031 Toggle req1 during SHIFT of a req0 word -> no gnt change, word result unaffected.
